// File: rtl/semaforo_fases_if.sv
// Lamp-phase sequencer signal bundle: timebase and direction grant in,
// six lamps plus phase/transition status out.
// Request semantics: ns_req/lo_req are levels, not a handshake; a request is
// valid only when exactly one of the two is high, and it is sampled on every
// clock edge with no acknowledge. tick is a one-cycle timebase enable.
interface semaforo_fases_if;
    logic       tick;
    logic       ns_req;
    logic       lo_req;
    logic       ns_verm;
    logic       ns_amar;
    logic       ns_verde;
    logic       lo_verm;
    logic       lo_amar;
    logic       lo_verde;
    logic [2:0] fase;
    logic       em_transicao;

    modport master (
        output tick, ns_req, lo_req,
        input  ns_verm, ns_amar, ns_verde, lo_verm, lo_amar, lo_verde,
        input  fase, em_transicao
    );

    modport slave (
        input  tick, ns_req, lo_req,
        output ns_verm, ns_amar, ns_verde, lo_verm, lo_amar, lo_verde,
        output fase, em_transicao
    );
endinterface

// File: rtl/semaforo_fases.sv
// Lamp-phase sequencer: turns the registered NS/LO direction grant into the
// six lamps of both approaches, enforcing minimum green, fixed yellow and an
// all-red clearance on each change of direction. Durations count tick pulses.
module semaforo_fases #(
    parameter int T_VERDE_MIN = 4,
    parameter int T_AMARELO   = 2,
    parameter int T_VERMELHO  = 1,
    parameter int CW          = 8
) (
    input logic              clock,
    input logic              reset_n,
    semaforo_fases_if.slave  bus
);

    typedef enum logic [2:0] {
        INIT_VERM  = 3'd0,
        NS_VERDE   = 3'd1,
        NS_AMAR    = 3'd2,
        VERM_NS_LO = 3'd3,
        LO_VERDE   = 3'd4,
        LO_AMAR    = 3'd5,
        VERM_LO_NS = 3'd6
    } fase_t;

    // Timer value at which green_ok is reached, and last timer value of
    // each timed state (the state exits on the tick seen at this value).
    localparam logic [CW-1:0] VERDE_SAT = CW'(T_VERDE_MIN);
    localparam logic [CW-1:0] ULT_AMAR  = CW'(T_AMARELO - 1);
    localparam logic [CW-1:0] ULT_VERM  = CW'(T_VERMELHO - 1);

    // Lamp vector order: {ns_verm, ns_amar, ns_verde, lo_verm, lo_amar, lo_verde}
    localparam logic [5:0] L_VERM     = 6'b100_100;
    localparam logic [5:0] L_NS_VERDE = 6'b001_100;
    localparam logic [5:0] L_NS_AMAR  = 6'b010_100;
    localparam logic [5:0] L_LO_VERDE = 6'b100_001;
    localparam logic [5:0] L_LO_AMAR  = 6'b100_010;

    fase_t         state_q, nxt_state, alvo;
    logic [CW-1:0] timer_q, nxt_timer, ultimo;
    logic          green_ok_q, nxt_green_ok;
    logic [5:0]    lamps_q, nxt_lamps;
    logic          em_q, nxt_em;
    logic          verde, pedido_oposto, req_ns, req_lo;

    // Next phase and timer: green states wait for green_ok plus a valid
    // opposite request; every other state (including the unused encoding,
    // which behaves as INIT_VERM) is a fixed-length tick countdown.
    always_comb begin
        req_ns        = bus.ns_req && !bus.lo_req;
        req_lo        = bus.lo_req && !bus.ns_req;
        verde         = 1'b0;
        ultimo        = ULT_VERM;
        alvo          = req_lo ? LO_VERDE : NS_VERDE;
        pedido_oposto = 1'b0;
        case (state_q)
            NS_VERDE:   begin verde = 1'b1; alvo = NS_AMAR; pedido_oposto = req_lo; end
            NS_AMAR:    begin ultimo = ULT_AMAR; alvo = VERM_NS_LO; end
            VERM_NS_LO: alvo = LO_VERDE;
            LO_VERDE:   begin verde = 1'b1; alvo = LO_AMAR; pedido_oposto = req_ns; end
            LO_AMAR:    begin ultimo = ULT_AMAR; alvo = VERM_LO_NS; end
            VERM_LO_NS: alvo = NS_VERDE;
            default:    ;
        endcase

        nxt_state = state_q;
        nxt_timer = timer_q;
        if (verde) begin
            // Exit does not need a tick; the timer only saturates at VERDE_SAT.
            if (green_ok_q && pedido_oposto) begin
                nxt_state = alvo;
                nxt_timer = '0;
            end else if (bus.tick && timer_q != VERDE_SAT) begin
                nxt_timer = timer_q + CW'(1);
            end
        end else if (bus.tick) begin
            if (timer_q == ultimo) begin
                nxt_state = alvo;
                nxt_timer = '0;
            end else begin
                nxt_timer = timer_q + CW'(1);
            end
        end

        nxt_green_ok = (nxt_state == NS_VERDE || nxt_state == LO_VERDE) &&
                       (nxt_timer == VERDE_SAT);
    end

    // Moore lamp decode of the next phase, so lamps register on the same
    // edge as the phase itself.
    always_comb begin
        nxt_lamps = L_VERM;
        nxt_em    = 1'b1;
        case (nxt_state)
            NS_VERDE: begin nxt_lamps = L_NS_VERDE; nxt_em = 1'b0; end
            NS_AMAR:  nxt_lamps = L_NS_AMAR;
            LO_VERDE: begin nxt_lamps = L_LO_VERDE; nxt_em = 1'b0; end
            LO_AMAR:  nxt_lamps = L_LO_AMAR;
            default:  ;
        endcase
    end

    // Phase register, timer, green_ok and all outputs; reset aborts any phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT_VERM;
            timer_q    <= '0;
            green_ok_q <= 1'b0;
            lamps_q    <= L_VERM;
            em_q       <= 1'b1;
        end else begin
            state_q    <= nxt_state;
            timer_q    <= nxt_timer;
            green_ok_q <= nxt_green_ok;
            lamps_q    <= nxt_lamps;
            em_q       <= nxt_em;
        end
    end

    assign bus.ns_verm      = lamps_q[5];
    assign bus.ns_amar      = lamps_q[4];
    assign bus.ns_verde     = lamps_q[3];
    assign bus.lo_verm      = lamps_q[2];
    assign bus.lo_amar      = lamps_q[1];
    assign bus.lo_verde     = lamps_q[0];
    assign bus.fase         = state_q;
    assign bus.em_transicao = em_q;

endmodule

// File: tb/tb_semaforo_fases.sv
// Bench for semaforo_fases: directed scenarios followed by a long random run,
// all compared against a tick-counting model of the phase rules.
module tb_semaforo_fases;
    localparam int TV = 4;
    localparam int TA = 2;
    localparam int TR = 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    semaforo_fases_if bus();

    semaforo_fases #(
        .T_VERDE_MIN(TV),
        .T_AMARELO  (TA),
        .T_VERMELHO (TR),
        .CW         (8)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;

    // Model: which approach owns the current cycle (0 = NS, 1 = LO), which
    // stage it is in (0 green, 1 yellow, 2 all-red, 3 start-up red) and how
    // many ticks that stage has seen so far.
    int m_dir;
    int m_etapa;
    int m_ticks;

    // Property trackers on the observed lamps
    logic prev_green;
    logic prev_amar;
    int   g_ticks;

    logic [2:0] seq_exp [8];

    function automatic logic [5:0] lamps_obs();
        return {bus.ns_verm, bus.ns_amar, bus.ns_verde,
                bus.lo_verm, bus.lo_amar, bus.lo_verde};
    endfunction

    function automatic logic [2:0] fase_exp();
        if (m_etapa == 3) return 3'd0;
        return 3'(1 + 3 * m_dir + m_etapa);
    endfunction

    function automatic logic [5:0] lamps_exp();
        logic [2:0] ns;
        logic [2:0] lo;
        ns = 3'b100;
        lo = 3'b100;
        if (m_etapa == 0) begin
            if (m_dir == 0) ns = 3'b001; else lo = 3'b001;
        end else if (m_etapa == 1) begin
            if (m_dir == 0) ns = 3'b010; else lo = 3'b010;
        end
        return {ns, lo};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dir      = 0;
        m_etapa    = 3;
        m_ticks    = 0;
        prev_green = 1'b0;
        prev_amar  = 1'b0;
        g_ticks    = 0;
    endtask

    // One clock edge of the phase rules, using the inputs seen at that edge.
    task automatic model_edge(input logic t, input logic n, input logic l);
        logic val_ns;
        logic val_lo;
        val_ns = n && !l;
        val_lo = l && !n;
        case (m_etapa)
            3: if (t) begin
                m_ticks++;
                if (m_ticks == TR) begin
                    m_etapa = 0;
                    m_dir   = val_lo ? 1 : 0;
                    m_ticks = 0;
                end
            end
            0: begin
                if (m_ticks >= TV && ((m_dir == 0) ? val_lo : val_ns)) begin
                    m_etapa = 1;
                    m_ticks = 0;
                end else if (t) begin
                    m_ticks++;
                end
            end
            1: if (t) begin
                m_ticks++;
                if (m_ticks == TA) begin
                    m_etapa = 2;
                    m_ticks = 0;
                end
            end
            default: if (t) begin
                m_ticks++;
                if (m_ticks == TR) begin
                    m_etapa = 0;
                    m_dir   = 1 - m_dir;
                    m_ticks = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("fase", bus.fase, fase_exp());
        chk("lamps", lamps_obs(), lamps_exp());
        chk("em_transicao", bus.em_transicao, m_etapa != 0);
    endtask

    task automatic check_props(input logic t);
        logic [5:0] lv;
        logic       cur_green;
        logic       cur_amar;
        lv        = lamps_obs();
        cur_green = lv[3] | lv[0];
        cur_amar  = lv[4] | lv[1];
        chk("ns_one_lamp", $countones(lv[5:3]), 1);
        chk("lo_one_lamp", $countones(lv[2:0]), 1);
        chk("one_side_red", lv[5] | lv[2], 1'b1);
        if (prev_green && cur_green) begin
            if (t) g_ticks++;
        end else if (prev_green && !cur_green) begin
            chk("green_min_ticks", g_ticks >= TV, 1'b1);
            g_ticks = 0;
        end
        if (prev_amar && !cur_amar) chk("yellow_then_red", lv[5] & lv[2], 1'b1);
        prev_green = cur_green;
        prev_amar  = cur_amar;
    endtask

    // Driver: apply inputs, take one edge, sample 1 time unit later.
    task automatic step(input logic t, input logic n, input logic l);
        bus.tick   = t;
        bus.ns_req = n;
        bus.lo_req = l;
        @(posedge clock);
        model_edge(t, n, l);
        #1;
        check_outputs();
        check_props(t);
    endtask

    initial begin
        int red_run;
        int lo_run;
        logic seen_lo_amar;
        logic [1:0] req;

        seq_exp = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4};

        // Reset with tick every cycle and NS requested
        bus.tick   = 1'b1;
        bus.ns_req = 1'b1;
        bus.lo_req = 1'b0;
        reset_n    = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_fase", bus.fase, 3'd0);
        chk("reset_lamps", lamps_obs(), 6'b100_100);
        chk("reset_em", bus.em_transicao, 1'b1);
        reset_n = 1'b1;
        #1;
        chk("init_red_after_release", lamps_obs(), 6'b100_100);
        step(1, 1, 0);
        chk("first_ns_green", lamps_obs(), 6'b001_100);
        step(1, 1, 0);
        step(1, 1, 0);

        // Asynchronous reset in the middle of NS green
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_fase", bus.fase, 3'd0);
        chk("async_reset_lamps", lamps_obs(), 6'b100_100);
        model_reset();
        @(posedge clock);
        #1 reset_n = 1'b1;
        step(1, 1, 0);
        chk("ns_green_again", bus.fase, 3'd1);

        // Switch to LO at green cycle 1: full change of direction
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 1);
            chk($sformatf("seq_%0d", i), bus.fase, seq_exp[i]);
        end

        // Tick every third cycle, always asking for the other direction
        red_run = 0;
        for (int i = 0; i < 90; i++) begin
            step((i % 3) == 2, m_dir == 1, m_dir == 0);
            if (bus.fase == 3'd3 || bus.fase == 3'd6) begin
                red_run++;
            end else if (red_run > 0) begin
                chk("red_3_clocks", red_run, 3 * TR);
                red_run = 0;
            end
        end

        // Freeze in NS_AMAR with no ticks
        for (int i = 0; i < 100 && !(m_etapa == 1 && m_dir == 0); i++)
            step(1, m_dir == 1, m_dir == 0);
        chk("reached_ns_amar", bus.fase, 3'd2);
        for (int i = 0; i < 50; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("frozen_ns_amar", bus.fase, 3'd2);
        end

        // Invalid requests while LO green already has green_ok
        for (int i = 0; i < 100 && !(m_etapa == 0 && m_dir == 1 && m_ticks >= TV); i++)
            step(1, 0, 1);
        chk("reached_lo_green_ok", bus.fase, 3'd4);
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(0, 1)), i < 10, i < 10);
            chk("invalid_req_hold_fase", bus.fase, 3'd4);
            chk("invalid_req_hold_lamps", lamps_obs(), 6'b100_001);
        end

        // Request reverses back to NS during NS_AMAR
        for (int i = 0; i < 100 && !(m_etapa == 1 && m_dir == 0); i++)
            step(1, m_dir == 1, m_dir == 0);
        chk("reached_ns_amar_2", bus.fase, 3'd2);
        lo_run       = 0;
        seen_lo_amar = 1'b0;
        for (int i = 0; i < 40 && !seen_lo_amar; i++) begin
            step(1, 1, 0);
            if (bus.fase == 3'd4) lo_run++;
            if (bus.fase == 3'd5) seen_lo_amar = 1'b1;
        end
        chk("reverse_reaches_lo_amar", seen_lo_amar, 1'b1);
        chk("reverse_lo_green_cycles", lo_run, TV + 1);

        // Random requests and ticks
        req = 2'b10;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 15) == 0) req = 2'($urandom_range(0, 3));
            step($urandom_range(0, 2) != 0, req[1], req[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
